vme_cmd_master: RTL and testbench

- Single-transaction bus initiator for the board-internal VME-style register bus.
- Takes one host request (read or write, device select, 10-bit command, 16-bit data) and drives it as a strobe transaction to the slave devices.
- Waits for the slave's open-drain DTACK_B, captures read data, and waits for DTACK release.
- Reports completion with a one-cycle DONE pulse plus a TIMEOUT flag; sits between the host command decoder and all register-slave blocks, including the status monitor.

---
 rtl/vme_cmd_master.sv | 194 +++++++++++++++++++
 tb/tb_vme_cmd_master.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vme_cmd_master.sv
// vme_cmd_master: single-transaction initiator for the board-internal
// VME-style register bus. Accepts one host request in IDLE, drives
// DEVICE/COMMAND/WRITE_B/INDATA, raises STROBE after a setup delay, waits for
// the open-drain DTACK_B acknowledge (bounded), captures read data, waits
// for DTACK release (bounded), then reports with a one-cycle DONE pulse.
//
// Ports:
//   FASTCLK, RST_B          clock, asynchronous active-low reset
//   REQ, REQ_WRITE, REQ_DEV, host request; REQ is sampled only in IDLE
//   REQ_CMD, REQ_WDATA
//   BUSY, DONE, TIMEOUT,    host status and captured read data
//   RDATA
//   STROBE, WRITE_B, DEVICE,bus outputs to the slave devices
//   COMMAND, INDATA
//   DTACK_B, OUTDATA        slave acknowledge (asserted only when exactly 0)
//                           and slave read data
module vme_cmd_master #(
    parameter int unsigned NDEV        = 8,
    parameter int unsigned DEVW        = 3,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic            FASTCLK,
    input  logic            RST_B,
    input  logic            REQ,
    input  logic            REQ_WRITE,
    input  logic [DEVW-1:0] REQ_DEV,
    input  logic [9:0]      REQ_CMD,
    input  logic [15:0]     REQ_WDATA,
    output logic            BUSY,
    output logic            DONE,
    output logic            TIMEOUT,
    output logic [15:0]     RDATA,
    output logic            STROBE,
    output logic            WRITE_B,
    output logic [NDEV-1:0] DEVICE,
    output logic [9:0]      COMMAND,
    output logic [15:0]     INDATA,
    input  logic            DTACK_B,
    input  logic [15:0]     OUTDATA
);

    // One shared counter serves the setup delay and both DTACK waits.
    localparam int unsigned CNT_MAX = (TIMEOUT_CYC > SETUP_CYC) ? TIMEOUT_CYC : SETUP_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STRB,
        S_RELEASE,
        S_FIN
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              strobe_n, write_b_n, busy_n, done_n, timeout_n;
    logic [NDEV-1:0]   device_n;
    logic [9:0]        command_n;
    logic [15:0]       indata_n, rdata_n;
    logic [NDEV-1:0]   dev_sel_c;

    // One-hot decode of the requested device; out-of-range index selects nobody.
    always_comb begin
        dev_sel_c = '0;
        for (int unsigned i = 0; i < NDEV; i++) begin
            if (REQ_DEV == DEVW'(i)) begin
                dev_sel_c[i] = 1'b1;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge FASTCLK or negedge RST_B) begin
        if (!RST_B) begin
            state   <= S_IDLE;
            cnt     <= '0;
            STROBE  <= 1'b0;
            WRITE_B <= 1'b1;
            DEVICE  <= '0;
            COMMAND <= '0;
            INDATA  <= '0;
            RDATA   <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            STROBE  <= strobe_n;
            WRITE_B <= write_b_n;
            DEVICE  <= device_n;
            COMMAND <= command_n;
            INDATA  <= indata_n;
            RDATA   <= rdata_n;
            BUSY    <= busy_n;
            DONE    <= done_n;
            TIMEOUT <= timeout_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        strobe_n  = STROBE;
        write_b_n = WRITE_B;
        device_n  = DEVICE;
        command_n = COMMAND;
        indata_n  = INDATA;
        rdata_n   = RDATA;
        busy_n    = BUSY;
        done_n    = 1'b0;
        timeout_n = TIMEOUT;

        unique case (state)
            S_IDLE: begin
                if (REQ) begin
                    command_n = REQ_CMD;
                    indata_n  = REQ_WDATA;
                    write_b_n = ~REQ_WRITE;
                    device_n  = dev_sel_c;
                    busy_n    = 1'b1;
                    timeout_n = 1'b0;
                    cnt_n     = '0;
                    state_n   = S_SETUP;
                end
            end

            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_n    = '0;
                    strobe_n = 1'b1;
                    state_n  = S_STRB;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            S_STRB: begin
                // Acknowledge wins over a timeout landing on the same edge.
                if (DTACK_B == 1'b0) begin
                    if (WRITE_B) begin
                        rdata_n = OUTDATA;
                    end
                    strobe_n = 1'b0;
                    cnt_n    = '0;
                    state_n  = S_RELEASE;
                end else if (cnt == TMO_LAST) begin
                    strobe_n  = 1'b0;
                    timeout_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = S_RELEASE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            S_RELEASE: begin
                // Only an exact 0 holds us here; z/x on the pulled-up line is a release.
                if (DTACK_B == 1'b0) begin
                    if (cnt == TMO_LAST) begin
                        timeout_n = 1'b1;
                        cnt_n     = '0;
                        done_n    = 1'b1;
                        state_n   = S_FIN;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else begin
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    state_n = S_FIN;
                end
            end

            S_FIN: begin
                busy_n    = 1'b0;
                device_n  = '0;
                strobe_n  = 1'b0;
                write_b_n = 1'b1;
                state_n   = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vme_cmd_master.sv
// Scoreboard bench for vme_cmd_master: a behavioural slave answers on devices
// 0..6 (device 7 is absent) with a programmable acknowledge latency and a
// programmable DTACK hold after strobe drop; expectations come from timing
// arithmetic and are checked by an independent monitor on every DONE.
module tb_vme_cmd_master;

    localparam int unsigned NDEV        = 8;
    localparam int unsigned DEVW        = 3;
    localparam int unsigned SETUP_CYC   = 2;
    localparam int unsigned TIMEOUT_CYC = 255;

    logic            FASTCLK = 1'b0;
    logic            RST_B   = 1'b0;
    logic            REQ     = 1'b0;
    logic            REQ_WRITE = 1'b0;
    logic [DEVW-1:0] REQ_DEV   = '0;
    logic [9:0]      REQ_CMD   = '0;
    logic [15:0]     REQ_WDATA = '0;
    logic            BUSY, DONE, TIMEOUT, STROBE, WRITE_B;
    logic [15:0]     RDATA, INDATA;
    logic [NDEV-1:0] DEVICE;
    logic [9:0]      COMMAND;
    logic            DTACK_B;
    logic [15:0]     OUTDATA;

    vme_cmd_master #(
        .NDEV(NDEV), .DEVW(DEVW), .SETUP_CYC(SETUP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .FASTCLK(FASTCLK), .RST_B(RST_B), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
        .REQ_DEV(REQ_DEV), .REQ_CMD(REQ_CMD), .REQ_WDATA(REQ_WDATA),
        .BUSY(BUSY), .DONE(DONE), .TIMEOUT(TIMEOUT), .RDATA(RDATA),
        .STROBE(STROBE), .WRITE_B(WRITE_B), .DEVICE(DEVICE), .COMMAND(COMMAND),
        .INDATA(INDATA), .DTACK_B(DTACK_B), .OUTDATA(OUTDATA)
    );

    always #5 FASTCLK = ~FASTCLK;

    int unsigned cyc = 0;
    always @(posedge FASTCLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic [NDEV-1:0] dev_onehot(input int d);
        logic [NDEV-1:0] v;
        v = '0;
        if (d >= 0 && d < int'(NDEV)) v[d] = 1'b1;
        return v;
    endfunction

    // ---------------- behavioural slave ----------------
    int          sl_lat  = 1;
    int          sl_hold = 0;
    logic [15:0] sl_data = '0;
    int          sl_phase = 0;
    int          sl_cnt   = 0;
    bit          sl_seen  = 0;

    always @(posedge FASTCLK or negedge RST_B) begin
        if (!RST_B) begin
            DTACK_B  <= 1'b1;
            OUTDATA  <= 16'h0000;
            sl_phase = 0;
            sl_cnt   = 0;
            sl_seen  = 0;
        end else begin
            if (sl_phase == 0) begin
                if ((DEVICE & 8'h7F) != 0) begin
                    sl_cnt  = 0;
                    sl_seen = 0;
                    if (sl_lat == 0) begin
                        DTACK_B  <= 1'b0;
                        OUTDATA  <= sl_data;
                        sl_phase = 2;
                    end else begin
                        sl_phase = 1;
                    end
                end
            end else if (sl_phase == 1) begin
                if (STROBE) begin
                    sl_cnt++;
                    if (sl_cnt >= sl_lat) begin
                        DTACK_B  <= 1'b0;
                        OUTDATA  <= sl_data;
                        sl_seen  = 1;
                        sl_phase = 2;
                    end
                end
            end else if (sl_phase == 2) begin
                if (STROBE) sl_seen = 1;
                else if (sl_seen) begin
                    sl_cnt   = 0;
                    sl_phase = 3;
                end
            end
            if (sl_phase == 3) begin
                if (sl_cnt >= sl_hold) begin
                    DTACK_B  <= 1'b1;
                    OUTDATA  <= ~sl_data;
                    sl_phase = 4;
                end else begin
                    sl_cnt++;
                end
            end
            if (sl_phase == 4 && (DEVICE & 8'h7F) == 0) sl_phase = 0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          write;
        int          dev;
        logic [9:0]  cmd;
        logic [15:0] wdata;
        logic [15:0] rdata;
        bit          tmo;
        int          slen;
        int          dlat;
        int unsigned acc;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] model_rdata = '0;
    bit          model_tmo   = 0;
    int          done_count  = 0;
    int          strobe_cnt  = 0;
    bit          unstable    = 0;

    // Monitor: bus-stability tracking and per-DONE comparison.
    always @(negedge FASTCLK) begin
        exp_t e;
        if (!RST_B) begin
            strobe_cnt = 0;
            unstable   = 0;
        end else begin
            if (STROBE) strobe_cnt++;
            if (BUSY && sbq.size() > 0) begin
                if (DEVICE !== dev_onehot(sbq[0].dev) || COMMAND !== sbq[0].cmd ||
                    INDATA !== sbq[0].wdata || WRITE_B !== ~sbq[0].write)
                    unstable = 1;
            end
            if (DONE) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got DONE=1 expected no pending transaction (t=%0t)", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("rdata",      RDATA, e.rdata);
                    chk("timeout",    TIMEOUT, e.tmo);
                    chk("strobe_len", strobe_cnt, e.slen);
                    chk("done_lat",   cyc - e.acc, e.dlat);
                    chk("bus_stable", unstable, 0);
                    chk("busy_at_done", BUSY, 1);
                end
                strobe_cnt = 0;
                unstable   = 0;
                done_count++;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Computes the expected outcome from the slave behaviour, then issues the request.
    task automatic issue(input bit wr, input int dev, input logic [9:0] cmd,
                         input logic [15:0] wd, input int lat, input int hold,
                         input logic [15:0] sd);
        exp_t e;
        int   ack;
        sl_lat  = lat;
        sl_hold = hold;
        sl_data = sd;
        if (dev < 7 && lat <= int'(TIMEOUT_CYC) - 1) begin
            ack = int'(SETUP_CYC) + 1 + lat;
            if (hold >= int'(TIMEOUT_CYC) - 1) begin
                e.dlat = ack + int'(TIMEOUT_CYC);
                e.tmo  = 1;
            end else begin
                e.dlat = ack + 2 + hold;
                e.tmo  = 0;
            end
            if (!wr) model_rdata = sd;
        end else begin
            ack    = int'(SETUP_CYC) + int'(TIMEOUT_CYC);
            e.dlat = ack + 1;
            e.tmo  = 1;
        end
        e.write = wr;
        e.dev   = dev;
        e.cmd   = cmd;
        e.wdata = wd;
        e.rdata = model_rdata;
        e.slen  = ack - int'(SETUP_CYC);
        model_tmo = e.tmo;
        REQ_WRITE = wr;
        REQ_DEV   = DEVW'(dev);
        REQ_CMD   = cmd;
        REQ_WDATA = wd;
        REQ       = 1'b1;
        @(posedge FASTCLK);
        #1;
        e.acc = cyc;
        sbq.push_back(e);
        REQ       = 1'b0;
        REQ_WRITE = 1'($urandom);
        REQ_DEV   = DEVW'($urandom);
        REQ_CMD   = 10'($urandom);
        REQ_WDATA = 16'($urandom);
    endtask

    task automatic wait_done(input int n0);
        int k;
        k = 0;
        while (done_count == n0 && k < 700) begin
            @(posedge FASTCLK);
            k++;
        end
        if (done_count == n0) begin
            checks++;
            failures++;
            $display("FAIL wait_done: got no DONE in %0d cycles expected one", k);
        end
        @(posedge FASTCLK);
        #1;
    endtask

    task automatic idle_checks();
        chk("idle_busy",    BUSY, 0);
        chk("idle_done",    DONE, 0);
        chk("idle_strobe",  STROBE, 0);
        chk("idle_device",  DEVICE, 0);
        chk("idle_write_b", WRITE_B, 1);
        chk("idle_timeout", TIMEOUT, model_tmo);
        chk("idle_rdata",   RDATA, model_rdata);
    endtask

    task automatic settle();
        int k;
        k = 0;
        while (DTACK_B !== 1'b1 && k < 400) begin
            @(posedge FASTCLK);
            k++;
        end
        repeat (2) @(posedge FASTCLK);
        #1;
    endtask

    task automatic run_txn(input bit wr, input int dev, input logic [9:0] cmd,
                           input logic [15:0] wd, input int lat, input int hold,
                           input logic [15:0] sd);
        int n0;
        n0 = done_count;
        issue(wr, dev, cmd, wd, lat, hold, sd);
        wait_done(n0);
        idle_checks();
        settle();
    endtask

    initial begin
        int n0;
        int k;
        repeat (3) @(posedge FASTCLK);
        #1;
        chk("rst_busy",    BUSY, 0);
        chk("rst_done",    DONE, 0);
        chk("rst_timeout", TIMEOUT, 0);
        chk("rst_rdata",   RDATA, 0);
        chk("rst_strobe",  STROBE, 0);
        chk("rst_write_b", WRITE_B, 1);
        chk("rst_device",  DEVICE, 0);
        chk("rst_command", COMMAND, 0);
        chk("rst_indata",  INDATA, 0);
        RST_B = 1'b1;
        repeat (2) @(posedge FASTCLK);
        #1;

        // Reference read, write with RDATA hold, absent device.
        run_txn(0, 0, 10'h000, 16'h1234, 1, 0, 16'h7E1B);
        run_txn(1, 2, 10'h005, 16'hA5C3, 1, 0, 16'h0F0F);
        run_txn(0, 7, 10'h3FF, 16'h5555, 1, 0, 16'hDEAD);
        // Stuck DTACK after strobe drop, then boundaries on both waits.
        run_txn(0, 3, 10'h111, 16'h0000, 2, 300, 16'hBEEF);
        run_txn(0, 4, 10'h222, 16'h0000, 254, 0, 16'hC0DE);
        run_txn(0, 5, 10'h0AA, 16'h0000, 1, 253, 16'h4321);
        run_txn(0, 6, 10'h155, 16'h0000, 3, 254, 16'h8765);
        // DTACK already low on entry to STRB.
        run_txn(0, 1, 10'h2C3, 16'h0000, 0, 0, 16'h9A9A);

        // REQ while busy is ignored; REQ in the IDLE cycle after FIN is taken.
        n0 = done_count;
        issue(0, 1, 10'h0F0, 16'h1111, 3, 1, 16'h6C6C);
        repeat (2) @(posedge FASTCLK);
        #1;
        REQ = 1'b1; REQ_WRITE = 1'b1; REQ_DEV = 3'd5; REQ_CMD = 10'h3A5; REQ_WDATA = 16'hFFFF;
        @(posedge FASTCLK);
        #1;
        REQ = 1'b0;
        k = 0;
        while (done_count == n0 && k < 700) begin
            @(negedge FASTCLK);
            k++;
        end
        @(posedge FASTCLK);
        #1;
        issue(1, 2, 10'h0C3, 16'h2468, 2, 0, 16'h1357);
        wait_done(n0 + 1);
        chk("two_done_pulses", done_count - n0, 2);
        idle_checks();
        settle();

        // Asynchronous reset in the middle of STRB.
        issue(0, 7, 10'h101, 16'hAAAA, 1, 0, 16'h0000);
        repeat (10) @(posedge FASTCLK);
        #2;
        chk("strobe_before_rst", STROBE, 1);
        n0 = done_count;
        RST_B = 1'b0;
        #1;
        chk("rst_async_strobe", STROBE, 0);
        chk("rst_async_device", DEVICE, 0);
        chk("rst_async_busy",   BUSY, 0);
        sbq.delete();
        model_rdata = '0;
        model_tmo   = 0;
        repeat (5) @(posedge FASTCLK);
        #1;
        chk("no_done_after_rst", done_count - n0, 0);
        RST_B = 1'b1;
        repeat (2) @(posedge FASTCLK);
        #1;
        run_txn(0, 2, 10'h077, 16'h0000, 1, 0, 16'h5A5A);

        // Randomized traffic.
        for (int i = 0; i < 24; i++) begin
            int d;
            d = (($urandom % 8) == 0) ? 7 : int'($urandom % 7);
            run_txn(1'($urandom), d, 10'($urandom), 16'($urandom),
                    int'($urandom % 6), int'($urandom % 4), 16'($urandom));
        end

        chk("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got no end of test expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
